router_reg: RTL

//  Datapath register stage of the 1x3 router, driven by the router FSM's state strobes.
//  - Latches the packet header.
//  - Presents each byte on dout for the FIFO write that follows.
//  - Holds the byte that arrived while the FIFO was full.
//  - Computes the running XOR parity and compares it with the packet's parity byte.
//  - Returns parity_done and low_pkt_valid to the FSM; flags err to the top level.

---
 rtl/router_reg.sv | 132 +++++++++++++
 1 files changed

// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: header latch, FIFO-full holding byte,
// running XOR parity and parity-error flag, all sequenced by the router FSM's state strobes.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] r_hdr;
    logic [DATA_WIDTH-1:0] r_ffsb;
    logic [DATA_WIDTH-1:0] r_intPar;
    logic [DATA_WIDTH-1:0] r_pktPar;
    logic                  r_parityDone;
    logic                  r_lowPktValid;
    logic                  r_err;

    logic w_hdrCapture;
    logic w_ldWrite;
    logic w_ldFull;
    logic w_lafLoad;

    // Destination 2'b11 does not exist, so such a header leaves every register untouched.
    assign w_hdrCapture = detect_add & pkt_valid & (data_in[1:0] != 2'b11);
    assign w_ldWrite    = ld_state & ~fifo_full & ~full_state;
    assign w_ldFull     = ld_state & fifo_full & ~full_state;
    assign w_lafLoad    = laf_state & ~full_state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_hdr <= '0;
        end else if (w_hdrCapture) begin
            r_hdr <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dout <= '0;
        end else if (lfd_state) begin
            r_dout <= r_hdr;
        end else if (w_ldWrite) begin
            r_dout <= data_in;
        end else if (w_lafLoad) begin
            r_dout <= r_ffsb;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ffsb <= '0;
        end else if (w_ldFull) begin
            r_ffsb <= data_in;
        end
    end

    // A payload byte is folded into the parity when it first arrives, even if it is parked in ffsb.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_intPar <= '0;
        end else if (w_hdrCapture) begin
            r_intPar <= '0;
        end else if (lfd_state) begin
            r_intPar <= r_intPar ^ r_hdr;
        end else if ((w_ldWrite | w_ldFull) & pkt_valid) begin
            r_intPar <= r_intPar ^ data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pktPar <= '0;
        end else if (w_hdrCapture) begin
            r_pktPar <= '0;
        end else if ((w_ldWrite | w_ldFull) & ~pkt_valid) begin
            r_pktPar <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lowPktValid <= 1'b0;
        end else if (rst_int_reg) begin
            r_lowPktValid <= 1'b0;
        end else if (ld_state & ~pkt_valid) begin
            r_lowPktValid <= 1'b1;
        end
    end

    // A parity byte parked during FIFO full only counts as done once LAF has replayed it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_parityDone <= 1'b0;
        end else if (w_hdrCapture) begin
            r_parityDone <= 1'b0;
        end else if (w_ldWrite & ~pkt_valid) begin
            r_parityDone <= 1'b1;
        end else if (w_lafLoad & r_lowPktValid & ~r_parityDone) begin
            r_parityDone <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_hdrCapture) begin
            r_err <= 1'b0;
        end else if (rst_int_reg) begin
            r_err <= (r_intPar != r_pktPar);
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parityDone;
    assign low_pkt_valid = r_lowPktValid;
    assign err           = r_err;

endmodule
